// File: rtl/modular_multiplier_barrett_pkg.sv
// Shared constants for the Kyber-modulus arithmetic blocks (multiplier and
// butterfly add/sub stage).
package modular_multiplier_barrett_pkg;

  localparam int unsigned M          = 3329;
  localparam int unsigned BARRETT_K  = 24;
  localparam int unsigned BARRETT_MU = 5039;   // floor(2^24 / 3329)
  localparam int unsigned DATA_WIDTH = 14;

  localparam int unsigned PROD_W     = 24;     // a*b for operands < M fits in 24 bits
  localparam int unsigned QHAT_W     = 13;
  localparam int unsigned RES_W      = 12;     // residues 0..3328
  localparam int unsigned PIPE_DEPTH = 4;

endpackage

// File: rtl/modular_multiplier_barrett_reduce.sv
// Three-stage Barrett reduction of a 24-bit product modulo M:
// quotient estimate, partial remainder, final conditional subtract.
module barrett_reduce
  import modular_multiplier_barrett_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [PROD_W-1:0] p,
  output logic [RES_W-1:0]  r
);

  localparam int unsigned T_W = PROD_W + QHAT_W;

  logic [T_W-1:0]    t;
  logic [QHAT_W-1:0] q_hat_d;
  logic [QHAT_W-1:0] q_hat_q;
  logic [13:0]       p_lo_q;
  logic [13:0]       r_d;
  logic [13:0]       r_q;
  logic [RES_W-1:0]  z_d;
  logic [RES_W-1:0]  z_q;

  always_comb begin
    t       = T_W'(p) * T_W'(BARRETT_MU);
    q_hat_d = QHAT_W'(t >> BARRETT_K);
  end

  // r < 2M < 2^14, so only the low 14 bits of p and q_hat*M are needed.
  always_comb r_d = p_lo_q - 14'(q_hat_q) * 14'(M);

  always_comb z_d = (r_q >= 14'(M)) ? RES_W'(r_q - 14'(M)) : RES_W'(r_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_hat_q <= '0;
      p_lo_q  <= '0;
      r_q     <= '0;
      z_q     <= '0;
    end else if (en) begin
      q_hat_q <= q_hat_d;
      p_lo_q  <= p[13:0];
      r_q     <= r_d;
      z_q     <= z_d;
    end
  end

  assign r = z_q;

endmodule

// File: rtl/modular_multiplier_barrett.sv
// Pipelined (a*b) mod 3329 with a 4-cycle latency and a sideband tag that
// travels in lockstep with each operation.
module modular_multiplier_barrett
  import modular_multiplier_barrett_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH,
  parameter int unsigned TAG_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [data_width-1:0] a_in,
  input  logic [data_width-1:0] b_in,
  input  logic [TAG_W-1:0]      tag_in,
  output logic                  out_valid,
  output logic [data_width-1:0] z_out,
  output logic [TAG_W-1:0]      tag_out
);

  logic [PROD_W-1:0]     p_q;
  logic [PIPE_DEPTH-1:0] valid_sr;
  logic [TAG_W-1:0]      tag_sr [PIPE_DEPTH];
  logic [RES_W-1:0]      r;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q      <= '0;
      valid_sr <= '0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) tag_sr[i] <= '0;
    end else if (en) begin
      p_q       <= PROD_W'(a_in) * PROD_W'(b_in);
      valid_sr  <= {valid_sr[PIPE_DEPTH-2:0], in_valid};
      tag_sr[0] <= tag_in;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  barrett_reduce u_reduce (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .p   (p_q),
    .r   (r)
  );

  // The reducer's last stage is the output register; only zero-extension here.
  assign z_out     = data_width'(r);
  assign out_valid = valid_sr[PIPE_DEPTH-1];
  assign tag_out   = tag_sr[PIPE_DEPTH-1];

endmodule

// File: tb/tb_modular_multiplier_barrett.sv
// Directed and swept checks of the Barrett multiplier against a scoreboard of
// expected residues, tags and arrival edges.
module tb_modular_multiplier_barrett;

  localparam int DW  = 14;
  localparam int TW  = 8;
  localparam int MOD = 3329;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic [DW-1:0] z_out;
  logic [TW-1:0] tag_out;

  typedef struct {
    int z;
    int tag;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   en_edges = 0;
  bit   mon_adv;

  modular_multiplier_barrett #(.data_width(DW), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .a_in      (a_in),
    .b_in      (b_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .z_out     (z_out),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // A result is new only when it appears after an edge with en=1 and rst=0.
  always @(posedge clk) begin
    mon_adv = en && !rst;
    if (mon_adv) en_edges++;
    @(negedge clk);
    if (mon_adv && out_valid !== 1'b0) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("z", 32'(z_out), e.z);
        check("tag", 32'(tag_out), e.tag);
        check("latency", en_edges, e.due);
      end
    end else if (mon_adv && exp_q.size() > 0 && exp_q[0].due == en_edges) begin
      check("missing_valid", 32'(out_valid), 1);
    end
  end

  task automatic drive(input logic v, input logic e, input int a, input int b, input int tg, input int ez);
    in_valid = v;
    en       = e;
    a_in     = DW'(a);
    b_in     = DW'(b);
    tag_in   = TW'(tg);
    if (v && e && !rst) exp_q.push_back('{ez, tg & 255, en_edges + LAT});
    @(posedge clk);
    #1;
  endtask

  task automatic hop(input int a, input int b, input int tg, input int ez);
    drive(1'b1, 1'b1, a, b, tg, ez);
  endtask

  task automatic op(input int a, input int b, input int tg);
    drive(1'b1, 1'b1, a, b, tg, (a * b) % MOD);
  endtask

  task automatic bubble();
    drive(1'b0, 1'b1, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) bubble();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; tag_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_z", 32'(z_out), 0);
    check("rst_tag", 32'(tag_out), 0);
    rst = 1'b0;

    // Single op, with explicit quiet cycles on both sides.
    hop(3328, 3328, 8'h11, 1);
    bubble(); check("pre_valid_1", 32'(out_valid), 0);
    bubble(); check("pre_valid_2", 32'(out_valid), 0);
    bubble();
    check("single_valid", 32'(out_valid), 1);
    check("single_z", 32'(z_out), 1);
    check("single_tag", 32'(tag_out), 8'h11);
    bubble(); check("post_valid", 32'(out_valid), 0);
    drain();

    // Back-to-back hand-computed vectors, including a q_hat undershoot case.
    hop(1665, 2, 1, 1);
    hop(3328, 2, 2, 3327);
    hop(0, 3328, 3, 0);
    hop(17, 17, 4, 289);
    hop(3328, 3327, 5, 2);
    hop(3328, 1, 6, 3328);
    drain();

    // Operand-range sweeps plus random pairs.
    for (int i = 0; i < MOD; i++) op(i, 3328, i);
    for (int i = 0; i < MOD; i++) op(3327, i, i + 7);
    for (int i = 0; i < 20000; i++) op(int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)), i);
    drain();

    // Enable dropped mid-stream with junk on the inputs.
    base = n_out;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) repeat (3) drive(1'b1, 1'b0, 3000, 3000, 8'hEE, 0);
      op(100 + i * 311, 2000 + i * 7, 8'h80 + i);
    end
    drain();
    check("en_count", n_out - base, 10);

    // Reset at cycle 2 of a stream discards everything in flight.
    op(1234, 2345, 8'hA1);
    op(2222, 3111, 8'hA2);
    rst = 1'b1;
    exp_q.delete();
    drive(1'b1, 1'b1, 5, 5, 8'h77, 0);
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_z", 32'(z_out), 0);
    check("midrst_tag", 32'(tag_out), 0);
    for (int i = 0; i < 6; i++) begin
      bubble();
      check("stale_valid", 32'(out_valid), 0);
    end
    hop(100, 200, 8'h42, 26);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
